// File: rtl/des_pkg.sv
// Purpose : shared DES constants (state encoding, shift schedule, permutation
//           index tables, S-boxes) plus the helper functions that apply them.
// Latency : none (package only); Backpressure: n/a.
// Tables use the DES bit numbering: entry n selects bit n counted from the MSB (1-based).
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Key-schedule rotation amount for each encryption round.
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int FP_TAB [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    // Parity bits (8, 16, ... 64) are never referenced and so drop out here.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // SBOX[box][row*16 + col], row/col laid out exactly as the published tables.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_TAB[i]];
        return o;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_TAB[i]];
        return o;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[55-i] = x[64-PC1_TAB[i]];
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47-i] = x[56-PC2_TAB[i]];
        return o;
    endfunction

    function automatic logic [47:0] expand_e(input logic [31:0] x);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47-i] = x[32-E_TAB[i]];
        return o;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[31-i] = x[32-P_TAB[i]];
        return o;
    endfunction

    // Outer bits of each 6-bit group pick the row, inner four bits the column.
    function automatic logic [31:0] sbox_sub(input logic [47:0] x);
        logic [31:0] o;
        logic [5:0]  b;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            b = x[47-6*i -: 6];
            o[31-4*i -: 4] = SBOX[i][{b[5], b[0], b[4:1]}];
        end
        return o;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_iter_ctrl_round_f.sv
// Purpose : DES f-function: E expansion, round-key XOR, 8 S-boxes, P permutation.
// Latency : combinational, 0 cycles. Ports: r in 32, k in 48, f out 32.
// Backpressure: none, pure logic.
module des_round_f
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);

    logic [47:0] mixed;

    always_comb begin
        mixed = expand_e(r) ^ k;
        f     = perm_p(sbox_sub(mixed));
    end

endmodule

// File: rtl/final_perm.sv
// Purpose : DES final permutation (FP = IP^-1). Ports: blk in 64, perm out 64.
// Latency : combinational, 0 cycles.
// Backpressure: none, pure wiring.
module final_perm
    import des_pkg::*;
(
    input  logic [63:0] blk,
    output logic [63:0] perm
);

    assign perm = perm_fp(blk);

endmodule

// File: rtl/init_perm.sv
// Purpose : DES initial permutation (IP). Ports: blk in 64, perm out 64.
// Latency : combinational, 0 cycles.
// Backpressure: none, pure wiring.
module init_perm
    import des_pkg::*;
(
    input  logic [63:0] blk,
    output logic [63:0] perm
);

    assign perm = perm_ip(blk);

endmodule

// File: rtl/des_iter_ctrl.sv
// Purpose : iterative DES engine, one Feistel round per clock with on-the-fly key schedule.
// Latency : 17 cycles accept-to-out_valid; one block in flight, initiation interval 18.
// Backpressure: in_ready low while busy; result held in DONE until out_ready.
// Ports   : clk, rst_n (async active-low); in_valid/in_ready/in_text/in_key/in_decrypt;
//           out_valid/out_ready/out_text (registered); busy (ROUND or DONE).
// Build   : define DES_DECRYPT_EN to honour in_decrypt; otherwise the engine always encrypts.
module des_iter_ctrl
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_text,
    input  logic [63:0] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_text,
    output logic        busy
);

    state_t      state, state_nxt;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  rnd_q;

    logic        accept;
    logic        last_rnd;
    logic [63:0] ip_blk;
    logic [63:0] fp_blk;
    logic [27:0] c_rot, d_rot;
    logic [47:0] rkey;
    logic [31:0] f_out;
    logic [31:0] l_nxt, r_nxt;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state == ST_ROUND) || (state == ST_DONE);
    assign accept   = in_valid && in_ready;
    assign last_rnd = (state == ST_ROUND) && (rnd_q == 4'd15);

`ifdef DES_DECRYPT_EN
    logic       dec_q;
    logic [3:0] rev_idx;

    // 16 - r modulo 16: walks the shift table backwards for r = 1..15.
    assign rev_idx = 4'd0 - rnd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= 1'b0;
        end else if (accept) begin
            dec_q <= in_decrypt;
        end
    end
`else
    logic unused_decrypt;
    assign unused_decrypt = in_decrypt;
`endif

    // Key schedule. Encryption rotates left before use. Decryption starts from
    // PC1(key), which is already C16/D16 (total rotation is 28), so round 0
    // uses it unrotated and later rounds step backwards with right rotations.
    always_comb begin
        c_rot = rotl28(c_q, SHIFT[rnd_q]);
        d_rot = rotl28(d_q, SHIFT[rnd_q]);
`ifdef DES_DECRYPT_EN
        if (dec_q) begin
            if (rnd_q == 4'd0) begin
                c_rot = c_q;
                d_rot = d_q;
            end else begin
                c_rot = rotr28(c_q, SHIFT[rev_idx]);
                d_rot = rotr28(d_q, SHIFT[rev_idx]);
            end
        end
`endif
        rkey = perm_pc2({c_rot, d_rot});
    end

    init_perm u_ip (
        .blk  (in_text),
        .perm (ip_blk)
    );

    des_round_f u_round_f (
        .r (r_q),
        .k (rkey),
        .f (f_out)
    );

    assign l_nxt = r_q;
    assign r_nxt = l_q ^ f_out;

    // Preoutput is {R16, L16}: the last round's halves go in swapped.
    final_perm u_fp (
        .blk  ({r_nxt, l_nxt}),
        .perm (fp_blk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid)       state_nxt = ST_ROUND;
            ST_ROUND: if (rnd_q == 4'd15) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready)      state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q   <= '0;
            r_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            rnd_q <= '0;
        end else if (accept) begin
            {l_q, r_q} <= ip_blk;
            {c_q, d_q} <= perm_pc1(in_key);
            rnd_q      <= '0;
        end else if (state == ST_ROUND) begin
            l_q <= l_nxt;
            r_q <= r_nxt;
            c_q <= c_rot;
            d_q <= d_rot;
            // Counter parks at 15 on the final round instead of wrapping.
            if (!last_rnd) begin
                rnd_q <= rnd_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_text  <= '0;
            out_valid <= 1'b0;
        end else if (last_rnd) begin
            out_text  <= fp_blk;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_des_iter_ctrl.sv
module tb_des_iter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_text = '0;
    logic [63:0] in_key = '0;
    logic        in_decrypt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_text;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    des_iter_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_text    (in_text),
        .in_key     (in_key),
        .in_decrypt (in_decrypt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_text   (out_text),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic [63:0] key, input logic [63:0] text, input logic dec);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        in_key     = key;
        in_text    = text;
        in_decrypt = dec;
        @(negedge clk);
        in_valid   = 1'b0;
        in_key     = 64'hA5A5_5A5A_C3C3_3C3C;
        in_text    = 64'h5A5A_A5A5_3C3C_C3C3;
        in_decrypt = ~dec;
    endtask

    // lat counts clock edges from the accept edge (inclusive) to out_valid.
    task automatic wait_done(output int lat, output logic bad);
        lat = 1;
        bad = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready || !busy) bad = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_block(input string tag, input logic [63:0] key, input logic [63:0] text,
                             input logic dec, input logic [63:0] exp);
        int   lat;
        logic bad;
        send(key, text, dec);
        wait_done(lat, bad);
        check({tag, "_result"}, out_text, exp);
        check({tag, "_latency"}, 64'(lat), 64'd17);
        check({tag, "_busy_rounds"}, 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_clr"}, 64'(out_valid), 64'd0);
        check({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    logic [63:0] bk [4] = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF,
                            64'h1111111111111111, 64'h0123456789ABCDEF};
    logic [63:0] bt [4] = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF,
                            64'h1111111111111111, 64'h4E6F772069732074};
    logic [63:0] bx [4] = '{64'h8CA64DE9C1B123A7, 64'h7359B2163E4EDC58,
                            64'hF40379AB9E0EC533, 64'h3FA40E8A984D4815};
    logic [63:0] got [4];
    int          acc [4];

    initial begin
        int          lat;
        logic        bad;
        logic [63:0] hold;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_text", out_text, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_block("enc1", 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405);
        run_block("enc2", 64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000);

`ifdef DES_DECRYPT_EN
        run_block("dec1", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF);
        run_block("dec2", 64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787);
`else
        run_block("dec_ignored", 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b1, 64'h85E813540F0AB405);
`endif

        // Backpressure: result must sit untouched in DONE while in_valid pulses.
        send(64'h0, 64'h0, 1'b0);
        wait_done(lat, bad);
        hold = out_text;
        check("bp_result", hold, 64'h8CA64DE9C1B123A7);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 2 == 0);
            in_key   = 64'h0123456789ABCDEF;
            in_text  = 64'hFEEDFACECAFEBEEF;
            @(negedge clk);
            if (!out_valid || in_ready || !busy || out_text !== hold) bad = 1'b1;
        end
        in_valid = 1'b0;
        check("bp_hold", 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_idle", 64'(in_ready), 64'd1);
        run_block("after_bp", 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h7359B2163E4EDC58);

        // Reset during round 7 aborts the block.
        send(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_text", out_text, 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid || !in_ready) bad = 1'b1;
        end
        check("abort_no_result", 64'(bad), 64'd0);
        run_block("post_rst", 64'h0123456789ABCDEF, 64'h1111111111111111, 1'b0, 64'h17668DFC7292532D);

        // Back-to-back with out_ready tied high.
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int n;
                    n = 0;
                    in_valid   = 1'b1;
                    in_key     = bk[i];
                    in_text    = bt[i];
                    in_decrypt = 1'b0;
                    while (!in_ready && n < 60) begin
                        @(negedge clk);
                        n++;
                    end
                    acc[i] = cyc;
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    int m;
                    m = 0;
                    while (!out_valid && m < 80) begin
                        @(negedge clk);
                        m++;
                    end
                    got[j] = out_valid ? out_text : 64'hX;
                    @(negedge clk);
                end
            end
        join
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) check($sformatf("b2b_result%0d", i), got[i], bx[i]);
        for (int i = 0; i < 3; i++) check($sformatf("b2b_interval%0d", i), 64'(acc[i+1] - acc[i]), 64'd18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_iter_ctrl.md
# des_iter_ctrl

Iterative DES engine controller that time-multiplexes a single Feistel round across 16 clock cycles instead of instantiating a fully unrolled 16-round stack. It accepts a 64-bit block and 64-bit key (parity bits included) over a valid/ready handshake, applies the initial permutation, sequences 16 rounds with an on-the-fly key schedule, applies the final permutation, and presents the result over a second valid/ready handshake. It sits between the host bus adapter and the rest of the crypto datapath as the area-optimised alternative to the combinational top.

## Interface
- Parameters: none; all DES constants are fixed.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input block and key valid.
- `in_ready` out 1: engine idle and able to accept input.
- `in_text` in 64: plaintext, or ciphertext when decrypting.
- `in_key` in 64: cipher key, parity bits not dropped.
- `in_decrypt` in 1: 1 = decrypt; sampled on accept.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_text` out 64: result block, registered.
- `busy` out 1: high in ROUND or DONE.

## Operation
- States: IDLE, ROUND, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid & in_ready`:
    - load {L,R} = IP(`in_text`).
    - load {C,D} = PC1(`in_key`).
    - latch decrypt flag.
    - set round counter to 0.
    - go to ROUND.
- ROUND: one round per cycle, counter r = 0..15.
  - Encrypt: rotate C and D left by SHIFT[r], then K = PC2(C,D).
  - Decrypt, r=0: no rotation, K = PC2(C,D), which equals K16.
  - Decrypt, r≥1: rotate C and D right by SHIFT[16−r], then K = PC2(C,D).
  - SHIFT = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}.
  - Round update: L ← R; R ← L ^ f(R,K).
  - At r=15: register `out_text` = FP({R',L'}) (halves swapped), set `out_valid`, go to DONE.
- DONE
  - `out_valid`=1.
  - `out_text` held stable while `out_valid`=1.
  - On `out_ready`: clear `out_valid` and go to IDLE.
  - `in_valid` is ignored in DONE; no accept in the same cycle as output.
- `in_text`, `in_key` and `in_decrypt` are don't-care outside the accept cycle.
- Counter is 4 bits and does not wrap during operation: exit happens at r=15.

## Timing
- Reset values:
  - state IDLE.
  - L, R, C, D, counter = 0.
  - `out_text` = 64'h0.
  - `out_valid` = 0.
  - `in_ready` = 1, combinational from state.
  - `busy` = 0.
- Accept in cycle T:
  - rounds execute on edges T+1..T+16.
  - `out_valid` rises at T+16 and is visible in cycle T+17.
- Latency 17 cycles from accept to first `out_valid`.
- Minimum initiation interval 18 cycles, with `out_ready` held high.
- Backpressure: DONE persists indefinitely while `out_ready`=0.
- `out_ready` high while not `out_valid` has no effect.
- Reset asserted mid-ROUND or in DONE: immediate abort; all state returns to reset values; partial result is discarded and never presented.

## Configuration
- `DES_DECRYPT_EN`
  - Defined: `in_decrypt` honoured; right-rotation path and reversed SHIFT indexing are built.
  - Undefined: `in_decrypt` port still present but ignored; decrypt flag forced to 0; only left rotation is synthesised; the engine always encrypts.

## Structure
- Package `des_pkg` holds:
  - state enum.
  - SHIFT table.
  - PC1, PC2, E, P, IP, FP index tables.
  - S-box tables.
- Sub-module `des_round_f`: combinational f-function (expansion, key XOR, 8 S-boxes, P permutation), 32-bit R + 48-bit K → 32-bit.
- Existing `init_perm` and `final_perm` are reused as-is for IP/FP.

## Test plan
- Encrypt: key 133457799BBCDFF1, text 0123456789ABCDEF → `out_text`=85E813540F0AB405; `out_valid` rises exactly 17 cycles after accept.
- Encrypt: key 0E329232EA6D0D73, text 8787878787878787 → 0000000000000000; `in_ready`=0 and `busy`=1 throughout rounds.
- Decrypt (with `DES_DECRYPT_EN`): key 133457799BBCDFF1, text 85E813540F0AB405, `in_decrypt`=1 → 0123456789ABCDEF. Without the macro, the same stimulus returns the encryption of 85E813540F0AB405.
- Backpressure: hold `out_ready`=0 for 20 cycles in DONE → `out_text` stable and `in_valid` pulses ignored; then `out_ready`=1 → IDLE next cycle, next block accepted.
- Reset abort: assert `rst_n`=0 at round 7 → `out_valid`=0, `out_text`=0, `in_ready`=1; the following block encrypts correctly with no residue.
- Back-to-back: 4 random blocks checked against a reference model with `out_ready` tied high → interval between accepts = 18 cycles.
